// File: rtl/mem_bus_access.sv
// Data-memory bus access stage: runs one req/addr_ok/data_ok transaction per
// accepted load or store, stalls the pipeline meanwhile, and returns extended load data.
module mem_bus_access #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reqValid,
    input  logic                  writeEnable,
    input  logic                  readEnable,
    input  logic [1:0]            widthCtrl,
    input  logic                  signExtend,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  flush,
    output logic                  stall,
    output logic                  readDataValid,
    output logic [DATA_WIDTH-1:0] readDataOut,
    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [1:0]            bus_size,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [3:0]            bus_wstrb,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_addr_ok,
    input  logic                  bus_data_ok,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);

    localparam logic [1:0] memWidth1 = 2'd0;
    localparam logic [1:0] memWidth2 = 2'd1;
    localparam logic [1:0] memWidth4 = 2'd2;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t                  state;
    state_t                  stateNext;
    logic                    accept;
    logic                    killed;
    logic                    latWr;
    logic [1:0]              latSize;
    logic [ADDR_WIDTH-1:0]   latAddr;
    logic [3:0]              latWstrb;
    logic [DATA_WIDTH-1:0]   latWdata;
    logic                    latSigned;

    function automatic logic [1:0] busSize(input logic [1:0] width);
        case (width)
            memWidth1: busSize = memWidth1;
            memWidth2: busSize = memWidth2;
            default:   busSize = memWidth4;
        endcase
    endfunction

    function automatic logic [3:0] laneStrobe(input logic [1:0] size, input logic [1:0] lowAddr);
        case (size)
            memWidth1: laneStrobe = 4'b0001 << lowAddr;
            memWidth2: laneStrobe = lowAddr[1] ? 4'b1100 : 4'b0011;
            default:   laneStrobe = 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extractLoad(
        input logic [DATA_WIDTH-1:0] rdata,
        input logic [1:0]            size,
        input logic [1:0]            lowAddr,
        input logic                  sgn
    );
        logic [DATA_WIDTH-1:0] shifted;
        logic [7:0]            byteVal;
        logic [15:0]           halfVal;
        shifted = rdata >> {lowAddr, 3'b000};
        byteVal = shifted[7:0];
        halfVal = lowAddr[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            memWidth1: extractLoad = {{24{sgn & byteVal[7]}}, byteVal};
            memWidth2: extractLoad = {{16{sgn & halfVal[15]}}, halfVal};
            default:   extractLoad = rdata;
        endcase
    endfunction

    assign accept = ((state == IDLE) || (state == DONE)) && reqValid &&
                    (readEnable || writeEnable) && !flush;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE: stateNext = accept ? REQ : IDLE;
            REQ: begin
                if (bus_addr_ok)
                    stateNext = RESP;
                else if (flush)
                    stateNext = IDLE;
            end
            RESP: begin
                if (bus_data_ok)
                    stateNext = DONE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Request latch, kill tracking and registered load result
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            killed        <= 1'b0;
            latWr         <= 1'b0;
            latSize       <= 2'd0;
            latAddr       <= '0;
            latWstrb      <= 4'd0;
            latWdata      <= '0;
            latSigned     <= 1'b0;
            readDataValid <= 1'b0;
            readDataOut   <= '0;
        end else begin
            state         <= stateNext;
            readDataValid <= 1'b0;
            if (accept) begin
                latWr     <= writeEnable;
                latSize   <= busSize(widthCtrl);
                latAddr   <= address;
                latWstrb  <= writeEnable ? laneStrobe(busSize(widthCtrl), address[1:0]) : 4'd0;
                latWdata  <= writeData;
                latSigned <= signExtend;
            end
            if (state == REQ && bus_addr_ok && flush)
                killed <= 1'b1;
            // A flush arriving with data_ok still suppresses the result.
            if (state == RESP) begin
                if (bus_data_ok) begin
                    killed <= 1'b0;
                    if (!latWr && !killed && !flush) begin
                        readDataOut   <= extractLoad(bus_rdata, latSize, latAddr[1:0], latSigned);
                        readDataValid <= 1'b1;
                    end
                end else if (flush) begin
                    killed <= 1'b1;
                end
            end
        end
    end

    // Bus side is driven purely from the latched request
    assign stall     = accept || (state == REQ) || (state == RESP);
    assign bus_req   = (state == REQ);
    assign bus_wr    = latWr;
    assign bus_size  = latSize;
    assign bus_addr  = latAddr;
    assign bus_wstrb = latWstrb;
    assign bus_wdata = latWdata;

endmodule
